// File: rtl/conv_mac_3x3.sv
// conv_mac_3x3: sequential 3x3 convolution MAC, one tap per clock.
// Define CONV_SIGNED_EN for two's-complement operands.
module conv_mac_3x3 #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 9,
  parameter int RES_W  = 64
) (
  input  logic                     CLKOUT,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [TAPS*DATA_W-1:0]   PATCH,
  input  logic [TAPS*DATA_W-1:0]   KERNEL,
  output logic [RES_W-1:0]         RESULT,
  output logic                     busy,
  output logic                     done
);

  localparam int VEC_W = TAPS * DATA_W;
  localparam int PRD_W = 2 * DATA_W;
  localparam int ACC_W = PRD_W + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [VEC_W-1:0]   p_q;
  logic [VEC_W-1:0]   k_q;
  logic [VEC_W-1:0]   p_sh;
  logic [VEC_W-1:0]   k_sh;
  logic [DATA_W-1:0]  p_cur;
  logic [DATA_W-1:0]  k_cur;
  logic [PRD_W-1:0]   prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc;
  logic [RES_W-1:0]   res_ext;
  logic [3:0]         idx;

  // Select tap idx by shifting it up to the MSB word
  always_comb begin
    p_sh  = p_q << (idx * DATA_W);
    k_sh  = k_q << (idx * DATA_W);
    p_cur = p_sh[VEC_W-1 -: DATA_W];
    k_cur = k_sh[VEC_W-1 -: DATA_W];
  end

`ifdef CONV_SIGNED_EN
  // Signed product, sign-extended into the accumulator and result
  always_comb begin
    prod     = $signed(p_cur) * $signed(k_cur);
    prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
    res_ext  = {{(RES_W-ACC_W){acc[ACC_W-1]}}, acc};
  end
`else
  // Unsigned product, zero-extended into the accumulator and result
  always_comb begin
    prod     = p_cur * k_cur;
    prod_ext = {{(ACC_W-PRD_W){1'b0}}, prod};
    res_ext  = {{(RES_W-ACC_W){1'b0}}, acc};
  end
`endif

  // State register
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; an out-of-range idx abandons the run
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_MAC;
      S_MAC: begin
        if (idx == 4'd8)     state_nx = S_DONE;
        else if (idx > 4'd8) state_nx = S_IDLE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status output
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Operand snapshot, accumulation and result publish
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      k_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      RESULT <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            p_q <= PATCH;
            k_q <= KERNEL;
            acc <= '0;
            idx <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 4'd1;
        end
        S_DONE: begin
          RESULT <= res_ext;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_3x3.sv
// tb_conv_mac_3x3: table vectors plus handshake corner sequences,
// results checked through an expected-result queue.
module tb_conv_mac_3x3;

  logic         CLKOUT;
  logic         rst_n;
  logic         start;
  logic [143:0] PATCH;
  logic [143:0] KERNEL;
  logic [63:0]  RESULT;
  logic         busy;
  logic         done;

  conv_mac_3x3 dut (
    .CLKOUT (CLKOUT),
    .rst_n  (rst_n),
    .start  (start),
    .PATCH  (PATCH),
    .KERNEL (KERNEL),
    .RESULT (RESULT),
    .busy   (busy),
    .done   (done)
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  typedef struct {
    logic [143:0] p;
    logic [143:0] k;
    logic [63:0]  res;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam logic [143:0] ONES = {9{16'h0001}};
  localparam logic [143:0] FFFF = {9{16'hFFFF}};
  localparam logic [143:0] UP   = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
                                   16'd6, 16'd7, 16'd8, 16'd9};
  localparam logic [143:0] DN   = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5,
                                   16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [143:0] K2   = {16'h0002, {8{16'h0000}}};

  always @(posedge CLKOUT) cyc <= cyc + 1;

  // Scoreboard: every done must match the oldest accepted start
  always @(negedge CLKOUT) begin
    if (done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at cycle %0d RESULT=%h", cyc, RESULT);
      end else begin
        e = sb.pop_front();
        if (RESULT !== e.res) begin
          errors++;
          $display("FAIL result got=%h exp=%h", RESULT, e.res);
        end
        checks++;
        if (cyc != e.cyc + 10) begin
          errors++;
          $display("FAIL latency done_cycle=%0d exp=%0d", cyc, e.cyc + 10);
        end
      end
    end
  end

  task automatic check1(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge
  task automatic go(input logic [143:0] p, input logic [143:0] k,
                    input logic [63:0] res);
    exp_t e;
    PATCH  = p;
    KERNEL = k;
    start  = 1'b1;
    @(posedge CLKOUT);
    #1;
    e.res = res;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge CLKOUT);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, bounded
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge CLKOUT);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout done=%b exp=1", nm, done);
    end
  endtask

  vec_t vt[$];

  initial begin
    logic [63:0] r3;
    logic [63:0] r6;
`ifdef CONV_SIGNED_EN
    r3 = 64'h9;
    r6 = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    r3 = 64'h0000_0008_FFEE_0009;
    r6 = 64'h0000_0000_0001_FFFE;
`endif
    vt.push_back('{ONES, ONES, 64'h9});
    vt.push_back('{UP,   DN,   64'hA5});
    vt.push_back('{FFFF, FFFF, r3});
    vt.push_back('{FFFF, K2,   r6});
    vt.push_back('{DN,   DN,   64'h11D});

    rst_n  = 1'b0;
    start  = 1'b0;
    PATCH  = '0;
    KERNEL = '0;
    repeat (2) @(negedge CLKOUT);
    check1("reset_result", RESULT, 64'h0);
    check1("reset_busy", {63'h0, busy}, 64'h0);
    check1("reset_done", {63'h0, done}, 64'h0);
    rst_n = 1'b1;
    @(negedge CLKOUT);

    // Busy profile across one run
    go(ONES, ONES, 64'h9);
    for (int i = 0; i < 10; i++) begin
      check1($sformatf("busy_c%0d", i), {63'h0, busy}, 64'h1);
      if (i < 9) @(negedge CLKOUT);
    end
    @(negedge CLKOUT);
    check1("busy_end", {63'h0, busy}, 64'h0);
    check1("done_end", {63'h0, done}, 64'h1);
    @(negedge CLKOUT);
    check1("done_pulse", {63'h0, done}, 64'h0);

    // Table vectors, back-to-back where possible
    foreach (vt[i]) begin
      go(vt[i].p, vt[i].k, vt[i].res);
      wait_done($sformatf("vec%0d", i));
    end
    @(negedge CLKOUT);

    // Start while busy is ignored; start in done cycle is accepted
    go(UP, DN, 64'hA5);
    @(negedge CLKOUT);
    @(negedge CLKOUT);
    PATCH = '0;
    start = 1'b1;
    @(negedge CLKOUT);
    start = 1'b0;
    wait_done("ignored_start");
    go(ONES, ONES, 64'h9);
    wait_done("back_to_back");
    @(negedge CLKOUT);

    // Reset mid-run aborts
    go(UP, DN, 64'hA5);
    repeat (4) @(negedge CLKOUT);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check1("abort_busy", {63'h0, busy}, 64'h0);
    check1("abort_done", {63'h0, done}, 64'h0);
    check1("abort_result", RESULT, 64'h0);
    @(negedge CLKOUT);
    rst_n = 1'b1;
    repeat (15) @(negedge CLKOUT);
    go(ONES, ONES, 64'h9);
    wait_done("after_abort");
    repeat (3) @(negedge CLKOUT);

    check1("sb_empty", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mac_3x3.md
Name: conv_mac_3x3

Overview:
Sequential 3x3 convolution engine. Sits directly downstream of the USB slave-FIFO controller and consumes its 9-word patch and 9-word kernel. Computes one multiply-accumulate per clock and returns a 64-bit result that the controller streams back as four 16-bit words. Uses a start/busy/done handshake, so the controller waits for done instead of a fixed cycle count.

Parameters:
DATA_W, 16, operand word width; only 16 is supported.
TAPS, 9, number of patch/kernel element pairs; only 9 is supported.
RES_W, 64, result width (4 x DATA_W).

Ports:
CLKOUT  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a computation; sampled only while in IDLE.
PATCH  input  144  9 patch words; element i = PATCH[143-16*i -: 16], so element 0 is the MSB word.
KERNEL  input  144  9 kernel words, same packing as PATCH.
RESULT  output  64  convolution sum; word k = RESULT[16*k+15 -: 16].
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when RESULT is updated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, RESULT=0, done=0, busy=0, accumulator=0, idx=0. Reset mid-computation aborts the computation, and outputs take reset values immediately.
- States:
  - IDLE, MAC and DONE are the only states.
  - IDLE: if start=1 at edge N, snapshot PATCH/KERNEL into internal regs, clear acc, set idx=0, go to MAC. Otherwise stay in IDLE.
  - MAC: each edge does acc += P[idx]*K[idx] and idx++. At the edge where idx==8, go to DONE. Edges N+1..N+9 are the 9 MACs.
  - DONE: at edge N+10, RESULT <= acc, done <= 1, go to IDLE. done is high for exactly one cycle, from edge N+10 to N+11.
- Latency: done is high 10 cycles after the start edge. Throughput is one result per 10 cycles.
- A start accepted in the cycle done is high is legal; it is back-to-back operation.
- start while busy=1 is ignored and not queued.
- Operand changes after the start edge have no effect because operands are snapshotted.
- RESULT holds its last value until the next done and is never partially updated.
- Arithmetic (unsigned default): 16x16 -> 32-bit product; acc is 36 bits; RESULT = zero-extended acc.
  - Maximum is 9*0xFFFE0001 < 2^36, so overflow cannot occur.
- idx is 4 bits. Values 9..15 are unreachable; if reached, go to IDLE without updating RESULT.

Optional Feature:
CONV_SIGNED_EN
- Defined: operands are two's-complement. Products are signed 32-bit, acc is signed 36-bit, and RESULT is the sign-extension of acc to 64 bits. The worst case, 9*2^30, fits.
- Not defined: operands are unsigned and zero-extended as above.
- Timing and handshake are identical in both builds.

Test Plan:
1. All 18 words = 0x0001, start pulse -> busy high for 10 cycles, done pulse at start+10, RESULT = 64'h9.
2. PATCH = 1..9, KERNEL = 9..1 (element 0 first), start -> RESULT = 64'h00A5 (165).
3. All words 0xFFFF, unsigned build -> RESULT = 64'h0000_0008_FFEE_0009, no wrap.
4. Sequence of operand and start events:
   - Start with test-2 operands.
   - At start+3, change PATCH to all zeros and pulse start again -> second start ignored, RESULT = 165, single done.
   - Then assert start in the done cycle -> new computation runs and done arrives 10 cycles later.
5. rst_n low at start+5 for 1 cycle -> busy=0, done=0, RESULT=0 immediately, and no done follows. A following start with test-1 operands -> RESULT = 9.
6. PATCH all 0xFFFF, KERNEL element 0 = 0x0002, others 0:
   - With CONV_SIGNED_EN -> RESULT = 64'hFFFF_FFFF_FFFF_FFFE.
   - Without it -> RESULT = 64'h0001_FFFE.
